stroke_capture: RTL and testbench

//  Upstream of the digit recogniser. Collects pen samples (x,y) into a 12x8 bitmap
//  and records start/end points of the first two strokes. Commits on i_done or on
//  pen-up timeout, then holds o_read_data_valid high until i_clear so the

---
 rtl/stroke_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_stroke_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_capture.sv
// Pen stroke capture: rasterises pen samples into a 12x8 bitmap and records
// the endpoints of the first two strokes. The result is frozen in DONE and
// presented with o_read_data_valid until i_clear.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | empty bitmap, waiting for the first pen-down sample
// STROKE | pen is down, samples extend the current stroke
// GAP    | pen lifted, timeout counter running, next pen-down starts a stroke
// DONE   | result frozen, o_read_data_valid high until i_clear
module stroke_capture #(
    parameter int COLS    = 12,
    parameter int ROWS    = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pt_valid,
    input  logic       i_pen_down,
    input  logic [3:0] i_x,
    input  logic [2:0] i_y,
    input  logic       i_done,
    input  logic       i_clear,
    output logic       o_read_data_valid,
    output logic [7:0] o_arr0,
    output logic [7:0] o_arr1,
    output logic [7:0] o_arr2,
    output logic [7:0] o_arr3,
    output logic [7:0] o_arr4,
    output logic [7:0] o_arr5,
    output logic [7:0] o_arr6,
    output logic [7:0] o_arr7,
    output logic [7:0] o_arr8,
    output logic [7:0] o_arr9,
    output logic [7:0] o_arr10,
    output logic [7:0] o_arr11,
    output logic [3:0] o_start_x0,
    output logic [2:0] o_start_y0,
    output logic [3:0] o_end_x0,
    output logic [2:0] o_end_y0,
    output logic [3:0] o_start_x1,
    output logic [2:0] o_start_y1,
    output logic [3:0] o_end_x1,
    output logic [2:0] o_end_y1,
    output logic [1:0] o_stroke_cnt,
    output logic       o_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROKE,
        S_GAP,
        S_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [COLS-1:0][ROWS-1:0]  bmp;
    logic [CW-1:0]              tmo_cnt;
    logic                       in_range;
    logic                       samp_ok;
    logic                       draw;
    logic                       lift;
    logic                       tmo_hit;

    // Sample qualification: a sample only counts when it is in range, the
    // result is not frozen and no clear is pending in the same cycle.
    always_comb begin
        in_range = ({1'b0, i_x} < 5'(COLS)) && ({1'b0, i_y} < 4'(ROWS));
        samp_ok  = i_pt_valid && in_range && (state != S_DONE) && !i_clear;
        draw     = samp_ok && i_pen_down;
        lift     = samp_ok && !i_pen_down;
        tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a sample in the i_done cycle is still applied by the
    // datapath, so DONE simply takes priority over the stroke/gap moves.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (draw) begin
                    state_nxt = i_done ? S_DONE : S_STROKE;
                end
            end
            S_STROKE: begin
                if (i_done) begin
                    state_nxt = S_DONE;
                end else if (lift) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (i_done) begin
                    state_nxt = S_DONE;
                end else if (draw) begin
                    state_nxt = S_STROKE;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_DONE;
        endcase
        if (i_clear) begin
            state_nxt = S_IDLE;
        end
    end

    // Output decode
    always_comb begin
        o_read_data_valid = (state == S_DONE);
    end

    // Bitmap, stroke endpoints, stroke count, error flag and pen-up timer
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bmp          <= '0;
            tmo_cnt      <= '0;
            o_start_x0   <= '0;
            o_start_y0   <= '0;
            o_end_x0     <= '0;
            o_end_y0     <= '0;
            o_start_x1   <= '0;
            o_start_y1   <= '0;
            o_end_x1     <= '0;
            o_end_y1     <= '0;
            o_stroke_cnt <= '0;
            o_err        <= 1'b0;
        end else if (i_clear) begin
            bmp          <= '0;
            tmo_cnt      <= '0;
            o_start_x0   <= '0;
            o_start_y0   <= '0;
            o_end_x0     <= '0;
            o_end_y0     <= '0;
            o_start_x1   <= '0;
            o_start_y1   <= '0;
            o_end_x1     <= '0;
            o_end_y1     <= '0;
            o_stroke_cnt <= '0;
            o_err        <= 1'b0;
        end else begin
            if (i_pt_valid && !in_range && (state != S_DONE)) begin
                o_err <= 1'b1;
            end

            for (int c = 0; c < COLS; c++) begin
                if (draw && (i_x == 4'(c))) begin
                    bmp[c][i_y] <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (draw) begin
                        o_stroke_cnt <= 2'd1;
                        o_start_x0   <= i_x;
                        o_start_y0   <= i_y;
                        o_end_x0     <= i_x;
                        o_end_y0     <= i_y;
                    end
                end
                S_STROKE: begin
                    // Strokes beyond the second draw pixels but keep no points.
                    if (draw && (o_stroke_cnt == 2'd1)) begin
                        o_end_x0 <= i_x;
                        o_end_y0 <= i_y;
                    end else if (draw && (o_stroke_cnt == 2'd2)) begin
                        o_end_x1 <= i_x;
                        o_end_y1 <= i_y;
                    end
                    if (lift) begin
                        tmo_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (draw) begin
                        if (o_stroke_cnt != 2'd3) begin
                            o_stroke_cnt <= o_stroke_cnt + 2'd1;
                        end
                        if (o_stroke_cnt == 2'd1) begin
                            o_start_x1 <= i_x;
                            o_start_y1 <= i_y;
                            o_end_x1   <= i_x;
                            o_end_y1   <= i_y;
                        end
                    end
                    if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_arr0  = bmp[0];
    assign o_arr1  = bmp[1];
    assign o_arr2  = bmp[2];
    assign o_arr3  = bmp[3];
    assign o_arr4  = bmp[4];
    assign o_arr5  = bmp[5];
    assign o_arr6  = bmp[6];
    assign o_arr7  = bmp[7];
    assign o_arr8  = bmp[8];
    assign o_arr9  = bmp[9];
    assign o_arr10 = bmp[10];
    assign o_arr11 = bmp[11];

endmodule

// File: tb/tb_stroke_capture.sv
// Bench for stroke_capture: directed pen traces with hand-computed results.
// Committed results go through a scoreboard queue; timing and clear-related
// behaviour is checked inline.
module tb_stroke_capture;

    localparam int TIMEOUT = 1000;

    logic       i_clk;
    logic       i_rst;
    logic       i_pt_valid;
    logic       i_pen_down;
    logic [3:0] i_x;
    logic [2:0] i_y;
    logic       i_done;
    logic       i_clear;
    logic       o_read_data_valid;
    logic [7:0] o_arr0, o_arr1, o_arr2, o_arr3, o_arr4, o_arr5;
    logic [7:0] o_arr6, o_arr7, o_arr8, o_arr9, o_arr10, o_arr11;
    logic [3:0] o_start_x0, o_end_x0, o_start_x1, o_end_x1;
    logic [2:0] o_start_y0, o_end_y0, o_start_y1, o_end_y1;
    logic [1:0] o_stroke_cnt;
    logic       o_err;

    typedef struct packed {
        logic [11:0][7:0] arr;
        logic [27:0]      pts;
        logic [1:0]       cnt;
        logic             err;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    stroke_capture #(.COLS(12), .ROWS(8), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pt_valid(i_pt_valid),
        .i_pen_down(i_pen_down), .i_x(i_x), .i_y(i_y), .i_done(i_done),
        .i_clear(i_clear), .o_read_data_valid(o_read_data_valid),
        .o_arr0(o_arr0), .o_arr1(o_arr1), .o_arr2(o_arr2), .o_arr3(o_arr3),
        .o_arr4(o_arr4), .o_arr5(o_arr5), .o_arr6(o_arr6), .o_arr7(o_arr7),
        .o_arr8(o_arr8), .o_arr9(o_arr9), .o_arr10(o_arr10), .o_arr11(o_arr11),
        .o_start_x0(o_start_x0), .o_start_y0(o_start_y0),
        .o_end_x0(o_end_x0), .o_end_y0(o_end_y0),
        .o_start_x1(o_start_x1), .o_start_y1(o_start_y1),
        .o_end_x1(o_end_x1), .o_end_y1(o_end_y1),
        .o_stroke_cnt(o_stroke_cnt), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [95:0] act_arr();
        return {o_arr11, o_arr10, o_arr9, o_arr8, o_arr7, o_arr6,
                o_arr5, o_arr4, o_arr3, o_arr2, o_arr1, o_arr0};
    endfunction

    function automatic logic [27:0] act_pts();
        return {o_start_x0, o_start_y0, o_end_x0, o_end_y0,
                o_start_x1, o_start_y1, o_end_x1, o_end_y1};
    endfunction

    function automatic logic [27:0] mkpts(input logic [3:0] sx0, input logic [2:0] sy0,
                                          input logic [3:0] ex0, input logic [2:0] ey0,
                                          input logic [3:0] sx1, input logic [2:0] sy1,
                                          input logic [3:0] ex1, input logic [2:0] ey1);
        return {sx0, sy0, ex0, ey0, sx1, sy1, ex1, ey1};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic samp(input logic pen, input logic [3:0] x, input logic [2:0] y,
                        input logic done);
        @(negedge i_clk);
        i_pt_valid = 1'b1;
        i_pen_down = pen;
        i_x        = x;
        i_y        = y;
        i_done     = done;
        @(posedge i_clk);
        #1;
        i_pt_valid = 1'b0;
        i_pen_down = 1'b0;
        i_done     = 1'b0;
    endtask

    task automatic pulse(input logic done, input logic clear);
        @(negedge i_clk);
        i_done  = done;
        i_clear = clear;
        @(posedge i_clk);
        #1;
        i_done  = 1'b0;
        i_clear = 1'b0;
    endtask

    // Monitor: each new assertion of o_read_data_valid is one committed result.
    always @(negedge i_clk) begin
        if (o_read_data_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 128'(1), 128'(0));
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_bitmap", 128'(act_arr()), 128'(e.arr));
                chk("sb_points", 128'(act_pts()), 128'(e.pts));
                chk("sb_stroke_cnt", 128'(o_stroke_cnt), 128'(e.cnt));
                chk("sb_err", 128'(o_err), 128'(e.err));
            end
        end
        prev_valid <= o_read_data_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t             e;
        logic [11:0][7:0] a;
        int               rise;

        i_rst = 1'b0; i_pt_valid = 1'b0; i_pen_down = 1'b0;
        i_x = '0; i_y = '0; i_done = 1'b0; i_clear = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_valid", 128'(o_read_data_valid), 128'(0));
        chk("reset_bitmap", 128'(act_arr()), 128'(0));
        chk("reset_points", 128'({act_pts(), o_stroke_cnt, o_err}), 128'(0));
        @(negedge i_clk);
        i_rst = 1'b1;

        // Test 1: vertical line in column 3
        a = '0; a[3] = 8'h7E;
        e.arr = a; e.pts = mkpts(4'd3, 3'd1, 4'd3, 3'd6, 4'd0, 3'd0, 4'd0, 3'd0);
        e.cnt = 2'd1; e.err = 1'b0;
        exp_q.push_back(e);
        for (int y = 1; y <= 6; y++) samp(1'b1, 4'd3, 3'(y), 1'b0);
        samp(1'b0, 4'd3, 3'd6, 1'b0);
        chk("t1_valid_before_done", 128'(o_read_data_valid), 128'(0));
        pulse(1'b1, 1'b0);
        chk("t1_valid_after_done", 128'(o_read_data_valid), 128'(1));
        pulse(1'b0, 1'b1);
        chk("t1_clear_valid", 128'(o_read_data_valid), 128'(0));

        // Test 2: horizontal then vertical stroke
        a = '0; a[1] = 8'h04; a[2] = 8'h04; a[3] = 8'h3F;
        a[4] = 8'h04; a[5] = 8'h04; a[6] = 8'h04;
        e.arr = a; e.pts = mkpts(4'd1, 3'd2, 4'd6, 3'd2, 4'd3, 3'd0, 4'd3, 3'd5);
        e.cnt = 2'd2; e.err = 1'b0;
        exp_q.push_back(e);
        for (int x = 1; x <= 6; x++) samp(1'b1, 4'(x), 3'd2, 1'b0);
        samp(1'b0, 4'd6, 3'd2, 1'b0);
        for (int y = 0; y <= 5; y++) samp(1'b1, 4'd3, 3'(y), 1'b0);
        samp(1'b0, 4'd3, 3'd5, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);

        // Test 3: pen-up timeout commit
        a = '0; a[5] = 8'h20;
        e.arr = a; e.pts = mkpts(4'd5, 3'd5, 4'd5, 3'd5, 4'd0, 3'd0, 4'd0, 3'd0);
        e.cnt = 2'd1; e.err = 1'b0;
        exp_q.push_back(e);
        samp(1'b1, 4'd5, 3'd5, 1'b0);
        samp(1'b0, 4'd5, 3'd5, 1'b0);
        rise = -1;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            @(posedge i_clk);
            #1;
            if (o_read_data_valid) begin
                rise = i;
                break;
            end
        end
        chk("t3_timeout_edge", 128'(rise), 128'(TIMEOUT));
        @(negedge i_clk);
        pulse(1'b0, 1'b1);

        // Test 4: out-of-range sample sets sticky error, bitmap unchanged
        a = '0; a[2] = 8'h08;
        samp(1'b1, 4'd2, 3'd3, 1'b0);
        samp(1'b1, 4'd12, 3'd0, 1'b0);
        chk("t4_err_set", 128'(o_err), 128'(1));
        chk("t4_bitmap_unchanged", 128'(act_arr()), 128'(a));
        chk("t4_end_unchanged", 128'({o_end_x0, o_end_y0}), 128'({4'd2, 3'd3}));
        a[2] = 8'h18;
        e.arr = a; e.pts = mkpts(4'd2, 3'd3, 4'd2, 3'd4, 4'd0, 3'd0, 4'd0, 3'd0);
        e.cnt = 2'd1; e.err = 1'b1;
        exp_q.push_back(e);
        samp(1'b1, 4'd2, 3'd4, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("t4_err_cleared", 128'(o_err), 128'(0));
        chk("t4_bitmap_cleared", 128'(act_arr()), 128'(0));
        pulse(1'b1, 1'b0);
        chk("t4_idle_ignores_done", 128'(o_read_data_valid), 128'(0));

        // Test 5: i_done and i_clear together in GAP
        samp(1'b1, 4'd7, 3'd7, 1'b0);
        samp(1'b0, 4'd7, 3'd7, 1'b0);
        pulse(1'b1, 1'b1);
        chk("t5_valid_low", 128'(o_read_data_valid), 128'(0));
        chk("t5_bitmap_cleared", 128'(act_arr()), 128'(0));
        chk("t5_cnt_cleared", 128'(o_stroke_cnt), 128'(0));
        repeat (3) @(posedge i_clk);
        #1;
        chk("t5_valid_stays_low", 128'(o_read_data_valid), 128'(0));

        // Test 6: four strokes, last sample arrives with i_done
        a = '0; a[0] = 8'h03; a[11] = 8'h80; a[10] = 8'h80;
        a[5] = 8'h08; a[6] = 8'h10; a[7] = 8'h10;
        e.arr = a; e.pts = mkpts(4'd0, 3'd0, 4'd0, 3'd1, 4'd11, 3'd7, 4'd10, 3'd7);
        e.cnt = 2'd3; e.err = 1'b0;
        exp_q.push_back(e);
        samp(1'b1, 4'd0, 3'd0, 1'b0);
        samp(1'b1, 4'd0, 3'd1, 1'b0);
        samp(1'b0, 4'd0, 3'd1, 1'b0);
        samp(1'b1, 4'd11, 3'd7, 1'b0);
        samp(1'b1, 4'd10, 3'd7, 1'b0);
        samp(1'b0, 4'd10, 3'd7, 1'b0);
        samp(1'b1, 4'd5, 3'd3, 1'b0);
        samp(1'b0, 4'd5, 3'd3, 1'b0);
        samp(1'b1, 4'd6, 3'd4, 1'b0);
        samp(1'b1, 4'd7, 3'd4, 1'b1);
        chk("t6_valid", 128'(o_read_data_valid), 128'(1));
        samp(1'b1, 4'd1, 3'd1, 1'b0);
        chk("t6_done_frozen", 128'(act_arr()), 128'(a));
        pulse(1'b0, 1'b1);

        // Async reset in the middle of a stroke
        samp(1'b1, 4'd4, 3'd4, 1'b0);
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_reset_bitmap", 128'(act_arr()), 128'(0));
        chk("async_reset_cnt", 128'(o_stroke_cnt), 128'(0));
        @(negedge i_clk);
        i_rst = 1'b1;

        repeat (3) @(posedge i_clk);
        #1;
        chk("sb_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
